medir_dht11_uc: RTL and testbench
=================================

Name: medir_dht11_uc

Overview:
Control unit paired with the DHT11 measurement datapath (`medir_dht11_fd`). It sequences one measurement request as follows:
- reset the sensor driver, then start it;
- supervise the reply window with the datapath's timeout counter;
- retry up to 4 attempts in total;
- register the result on success, or report an error.

It drives every control input of the datapath and consumes its status outputs. It exposes a single request/done handshake to the system-level controller.

Parameters:
ESPERA_ENTRE_TENTATIVAS, 1, 1 = after a failed attempt, wait one full timeout period before retrying (sensor recovery); 0 = retry immediately

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset; FSM to INICIAL
medir  input  1  measurement request, sampled in INICIAL only
pronto_medida  input  1  sensor driver finished with valid data
erro_medida  input  1  sensor driver reported protocol/checksum error
fim_tentativas  input  1  attempt counter at last value (4th attempt)
timeout  input  1  timeout counter reached end of count
reset_medida  output  1  resets sensor driver
start_medida  output  1  starts one sensor transaction
registra_medida  output  1  loads temperature/humidity registers
zera_tentativas  output  1  clears attempt counter
zera_timeout  output  1  clears timeout counter
conta_tentativas  output  1  increments attempt counter
conta_timeout  output  1  enables timeout counter
pronto  output  1  one-cycle pulse: new measurement registered
erro  output  1  one-cycle pulse: all attempts failed
db_estado  output  4  current state code, for debug display

Behaviour:
- Structure and reset:
  - Moore FSM; all outputs are decoded from the registered state only.
  - reset (async, any time, including mid-transaction) forces INICIAL.
  - In INICIAL all control outputs, pronto and erro are 0, and db_estado = 4'h0.
- States (db_estado code):
  - INICIAL (0): outputs 0. If medir=1, go to PREPARA; otherwise stay.
  - PREPARA (1): reset_medida=1, zera_tentativas=1, zera_timeout=1. Go to INICIA.
  - INICIA (2): start_medida=1 for exactly one cycle; zera_timeout=1. Go to AGUARDA.
  - AGUARDA (3): conta_timeout=1. Exits, in priority order:
    - pronto_medida=1: go to REGISTRA;
    - else erro_medida=1 or timeout=1: go to FALHA;
    - else stay.
  - REGISTRA (4): registra_medida=1. Go to CONCLUIDO.
  - CONCLUIDO (5): pronto=1. Go to INICIAL.
  - FALHA (6): no outputs.
    - fim_tentativas=1: go to ERRO.
    - else ESPERA_ENTRE_TENTATIVAS=1: go to RECUPERA.
    - else: go to NOVA_TENTATIVA.
  - RECUPERA (7): reset_medida=1, zera_timeout=1. Go to ESPERA.
  - ESPERA (8): conta_timeout=1, reset_medida=1. If timeout=1, go to NOVA_TENTATIVA.
  - NOVA_TENTATIVA (9): conta_tentativas=1, reset_medida=1, zera_timeout=1. Go to INICIA.
  - ERRO (A): erro=1. Go to INICIAL.
  - Unused codes (B..F): go to INICIAL.
- Attempt count:
  - Counter is cleared in PREPARA and incremented once per failed non-final attempt.
  - fim_tentativas asserts on counter value 3, so a request makes exactly 4 start_medida pulses before ERRO.
- Handshake:
  - medir is level- or pulse-tolerant but is only looked at in INICIAL; requests while busy are ignored.
  - pronto and erro are mutually exclusive single-cycle pulses; exactly one of them follows each accepted request.
- Timing:
  - Success latency = (cycles in AGUARDA until pronto_medida) + 4 cycles from medir to pronto: PREPARA, INICIA, REGISTRA, CONCLUIDO.
- Simultaneous events:
  - pronto_medida with erro_medida or timeout in the same cycle: success wins.
  - medir=1 during CONCLUIDO or ERRO: not accepted until back in INICIAL.
- Counter reset vs. count:
  - zera_timeout and conta_timeout are never asserted together.
  - conta_tentativas is never asserted together with zera_tentativas.

Test Plan:
- Success on first attempt:
  - Stimulus: reset, medir pulse; bench raises pronto_medida 10 cycles after start_medida.
  - Response: states 0→1→2→3→4→5→0; one start_medida, one registra_medida, pronto pulse 1 cycle; erro never set; conta_tentativas never set.
- Two erro_medida failures then success (ESPERA_ENTRE_TENTATIVAS=1, timeout modelled as 20-cycle counter):
  - Response: 3 start_medida pulses total; each retry passes 6→7→8→9; 20-cycle gap held in ESPERA with reset_medida=1; single pronto.
- Four timeouts, with fim_tentativas modelled by the bench counter:
  - Response: exactly 4 start_medida, 3 conta_tentativas, then state A and erro pulse 1 cycle; registra_medida never set.
- Same as the previous scenario with ESPERA_ENTRE_TENTATIVAS=0:
  - Response: FALHA→NOVA_TENTATIVA→INICIA with no ESPERA; db_estado never 7 or 8.
- pronto_medida and timeout both high in the same AGUARDA cycle:
  - Response: next state REGISTRA (4), not FALHA.
- Async reset and ignored request:
  - reset asserted mid-ESPERA, between clock edges: all outputs 0 and db_estado=0 immediately, without waiting for a clock edge.
  - medir held high during AGUARDA: no extra PREPARA entry after pronto until medir is seen in INICIAL.

Source files
------------

// File: rtl/medir_dht11_uc.sv
// Control unit for the DHT11 measurement datapath: runs one request through
// up to four sensor attempts and reports success (pronto) or failure (erro).
module medir_dht11_uc #(
  parameter bit ESPERA_ENTRE_TENTATIVAS = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       medir,
  input  logic       pronto_medida,
  input  logic       erro_medida,
  input  logic       fim_tentativas,
  input  logic       timeout,
  output logic       reset_medida,
  output logic       start_medida,
  output logic       registra_medida,
  output logic       zera_tentativas,
  output logic       zera_timeout,
  output logic       conta_tentativas,
  output logic       conta_timeout,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARA        = 4'h1,
    INICIA         = 4'h2,
    AGUARDA        = 4'h3,
    REGISTRA       = 4'h4,
    CONCLUIDO      = 4'h5,
    FALHA          = 4'h6,
    RECUPERA       = 4'h7,
    ESPERA         = 4'h8,
    NOVA_TENTATIVA = 4'h9,
    ERRO           = 4'hA
  } estado_t;

  estado_t estado_q, estado_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado_q <= INICIAL;
    else       estado_q <= estado_d;
  end

  always_comb begin
    estado_d         = estado_q;
    reset_medida     = 1'b0;
    start_medida     = 1'b0;
    registra_medida  = 1'b0;
    zera_tentativas  = 1'b0;
    zera_timeout     = 1'b0;
    conta_tentativas = 1'b0;
    conta_timeout    = 1'b0;
    pronto           = 1'b0;
    erro             = 1'b0;
    unique case (estado_q)
      INICIAL: if (medir) estado_d = PREPARA;
      PREPARA: begin
        reset_medida    = 1'b1;
        zera_tentativas = 1'b1;
        zera_timeout    = 1'b1;
        estado_d        = INICIA;
      end
      INICIA: begin
        start_medida = 1'b1;
        zera_timeout = 1'b1;
        estado_d     = AGUARDA;
      end
      AGUARDA: begin
        conta_timeout = 1'b1;
        // a valid reading wins over an error/timeout seen in the same cycle
        if (pronto_medida)                estado_d = REGISTRA;
        else if (erro_medida || timeout)  estado_d = FALHA;
      end
      REGISTRA: begin
        registra_medida = 1'b1;
        estado_d        = CONCLUIDO;
      end
      CONCLUIDO: begin
        pronto   = 1'b1;
        estado_d = INICIAL;
      end
      FALHA: begin
        if (fim_tentativas)               estado_d = ERRO;
        else if (ESPERA_ENTRE_TENTATIVAS) estado_d = RECUPERA;
        else                              estado_d = NOVA_TENTATIVA;
      end
      RECUPERA: begin
        reset_medida = 1'b1;
        zera_timeout = 1'b1;
        estado_d     = ESPERA;
      end
      ESPERA: begin
        conta_timeout = 1'b1;
        reset_medida  = 1'b1;
        if (timeout) estado_d = NOVA_TENTATIVA;
      end
      NOVA_TENTATIVA: begin
        conta_tentativas = 1'b1;
        reset_medida     = 1'b1;
        zera_timeout     = 1'b1;
        estado_d         = INICIA;
      end
      ERRO: begin
        erro     = 1'b1;
        estado_d = INICIAL;
      end
      default: estado_d = INICIAL;
    endcase
  end

  assign db_estado = estado_q;

endmodule

// File: tb/tb_medir_dht11_uc.sv
// Bench for medir_dht11_uc: two instances (with and without recovery wait),
// each wired to a small behavioural datapath/sensor model.
module tb_medir_dht11_uc;
  localparam int TO_LIM = 20;

  logic clock = 1'b0;
  logic reset;
  logic medir[2], pronto_medida[2], erro_medida[2], fim_tentativas[2], timeout[2];
  logic reset_medida[2], start_medida[2], registra_medida[2], zera_tentativas[2];
  logic zera_timeout[2], conta_tentativas[2], conta_timeout[2], pronto[2], erro[2];
  logic [3:0] db_estado[2];

  always #5 clock = ~clock;

  medir_dht11_uc #(.ESPERA_ENTRE_TENTATIVAS(1'b1)) u_dut_espera (
    .clock(clock), .reset(reset), .medir(medir[0]),
    .pronto_medida(pronto_medida[0]), .erro_medida(erro_medida[0]),
    .fim_tentativas(fim_tentativas[0]), .timeout(timeout[0]),
    .reset_medida(reset_medida[0]), .start_medida(start_medida[0]),
    .registra_medida(registra_medida[0]), .zera_tentativas(zera_tentativas[0]),
    .zera_timeout(zera_timeout[0]), .conta_tentativas(conta_tentativas[0]),
    .conta_timeout(conta_timeout[0]), .pronto(pronto[0]), .erro(erro[0]),
    .db_estado(db_estado[0]));

  medir_dht11_uc #(.ESPERA_ENTRE_TENTATIVAS(1'b0)) u_dut_direto (
    .clock(clock), .reset(reset), .medir(medir[1]),
    .pronto_medida(pronto_medida[1]), .erro_medida(erro_medida[1]),
    .fim_tentativas(fim_tentativas[1]), .timeout(timeout[1]),
    .reset_medida(reset_medida[1]), .start_medida(start_medida[1]),
    .registra_medida(registra_medida[1]), .zera_tentativas(zera_tentativas[1]),
    .zera_timeout(zera_timeout[1]), .conta_tentativas(conta_tentativas[1]),
    .conta_timeout(conta_timeout[1]), .pronto(pronto[1]), .erro(erro[1]),
    .db_estado(db_estado[1]));

  // Datapath/sensor model. plan_q entry per attempt: >0 pronto after N cycles,
  // <0 erro after -N cycles, 0 no reply (timeout).
  int plan_q[$];
  int tent[2], tcnt[2], pend[2];
  logic ativo[2], resp_erro[2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      fim_tentativas[i] = (tent[i] == 3);
      timeout[i]        = (tcnt[i] == TO_LIM - 1);
      pronto_medida[i]  = ativo[i] && (pend[i] == 1) && !resp_erro[i];
      erro_medida[i]    = ativo[i] && (pend[i] == 1) && resp_erro[i];
    end
  end

  always @(posedge clock or posedge reset) begin
    int d;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        tent[i] <= 0; tcnt[i] <= 0; pend[i] <= 0;
        ativo[i] <= 1'b0; resp_erro[i] <= 1'b0;
      end else begin
        if (zera_tentativas[i])       tent[i] <= 0;
        else if (conta_tentativas[i]) tent[i] <= tent[i] + 1;
        if (zera_timeout[i])          tcnt[i] <= 0;
        else if (conta_timeout[i])    tcnt[i] <= (tcnt[i] == TO_LIM - 1) ? 0 : tcnt[i] + 1;
        if (start_medida[i]) begin
          d = (plan_q.size() != 0) ? plan_q.pop_front() : 0;
          ativo[i]     <= (d != 0);
          resp_erro[i] <= (d < 0);
          pend[i]      <= (d < 0) ? -d : d;
        end else if (reset_medida[i]) begin
          ativo[i] <= 1'b0;
        end else if (ativo[i]) begin
          if (pend[i] == 1) ativo[i] <= 1'b0;
          pend[i] <= pend[i] - 1;
        end
      end
    end
  end

  // Scoreboard: one entry per accepted request, popped on pronto/erro.
  typedef struct { int inst; bit is_erro; int starts; } exp_t;
  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int n_start[2] = '{0, 0};
  int n_reg[2]   = '{0, 0};
  int n_ct[2]    = '{0, 0};
  int n_78[2]    = '{0, 0};
  int att[2]     = '{0, 0};

  always @(negedge clock) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        att[i] = 0;
      end else begin
        if (start_medida[i]) begin n_start[i]++; att[i]++; end
        if (registra_medida[i]) n_reg[i]++;
        if (conta_tentativas[i]) n_ct[i]++;
        if (db_estado[i] == 4'h7 || db_estado[i] == 4'h8) n_78[i]++;
        total++;
        if (zera_timeout[i] && conta_timeout[i]) begin
          bad++; $display("FAIL excl_timeout inst=%0d got zera&conta=1 want 0", i);
        end
        total++;
        if (zera_tentativas[i] && conta_tentativas[i]) begin
          bad++; $display("FAIL excl_tentativas inst=%0d got zera&conta=1 want 0", i);
        end
        total++;
        if (pronto[i] && erro[i]) begin
          bad++; $display("FAIL excl_pronto_erro inst=%0d got both=1 want 0", i);
        end
        if (pronto[i] || erro[i]) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL sb_unexpected inst=%0d got erro=%0b with empty queue", i, erro[i]);
          end else begin
            e = exp_q.pop_front();
            if (e.inst != i || e.is_erro != erro[i] || e.starts != att[i]) begin
              bad++;
              $display("FAIL sb_result got inst=%0d erro=%0b starts=%0d want inst=%0d erro=%0b starts=%0d",
                       i, erro[i], att[i], e.inst, e.is_erro, e.starts);
            end
          end
          att[i] = 0;
        end
      end
    end
  end

  logic [63:0] tr_sig;
  int esp_len_q[$];
  int esp_rm0;
  bit coinc;

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic run_until_done(input int i, input int budget, output int cycles,
                                output bit got_erro, output bit ok);
    logic [3:0] last;
    int run8;
    tr_sig = 64'(db_estado[i]); last = db_estado[i];
    esp_len_q.delete(); esp_rm0 = 0; coinc = 1'b0; run8 = 0;
    cycles = 0; got_erro = 1'b0; ok = 1'b0;
    while (cycles < budget && !ok) begin
      @(negedge clock); cycles++;
      if (cycles == 1) medir[i] = 1'b0;
      if (db_estado[i] != last) begin
        tr_sig = {tr_sig[59:0], db_estado[i]};
        if (last == 4'h8) begin esp_len_q.push_back(run8); run8 = 0; end
        last = db_estado[i];
      end
      if (db_estado[i] == 4'h8) begin run8++; if (!reset_medida[i]) esp_rm0++; end
      if (db_estado[i] == 4'h3 && pronto_medida[i] && timeout[i]) coinc = 1'b1;
      if (pronto[i] || erro[i]) begin ok = 1'b1; got_erro = erro[i]; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; medir[0] = 1'b0; medir[1] = 1'b0;
    cyc(2);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (db_estado[i] !== 4'h0) begin
        bad++; $display("FAIL reset_state inst=%0d got %h want 0", i, db_estado[i]);
      end
      total++;
      if ({reset_medida[i], start_medida[i], registra_medida[i], zera_tentativas[i], zera_timeout[i],
           conta_tentativas[i], conta_timeout[i], pronto[i], erro[i]} !== 9'b0) begin
        bad++; $display("FAIL reset_outputs inst=%0d got nonzero want 0", i);
      end
    end
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_success();
    int cycles, s0, r0, c0; bit ge, ok;
    s0 = n_start[0]; r0 = n_reg[0]; c0 = n_ct[0];
    plan_q.push_back(10);
    exp_q.push_back('{0, 1'b0, 1});
    medir[0] = 1'b1;
    run_until_done(0, 100, cycles, ge, ok);
    total++;
    if (!ok || ge) begin bad++; $display("FAIL success_done got ok=%0b erro=%0b want ok=1 erro=0", ok, ge); end
    total++;
    if (cycles != 14) begin bad++; $display("FAIL success_latency got %0d want 14", cycles); end
    total++;
    if (tr_sig !== 64'h012345) begin bad++; $display("FAIL success_trace got %h want 012345", tr_sig); end
    total++;
    if (n_start[0] - s0 != 1 || n_reg[0] - r0 != 1 || n_ct[0] - c0 != 0) begin
      bad++; $display("FAIL success_counts got start=%0d reg=%0d ct=%0d want 1 1 0",
                      n_start[0] - s0, n_reg[0] - r0, n_ct[0] - c0);
    end
    cyc(1);
    total++;
    if (pronto[0] !== 1'b0 || db_estado[0] !== 4'h0) begin
      bad++; $display("FAIL success_pulse got pronto=%0b state=%h want 0 0", pronto[0], db_estado[0]);
    end
  endtask

  task automatic test_retry_success();
    int cycles, s0; bit ge, ok;
    s0 = n_start[0];
    plan_q.push_back(-5); plan_q.push_back(-5); plan_q.push_back(10);
    exp_q.push_back('{0, 1'b0, 3});
    medir[0] = 1'b1;
    run_until_done(0, 300, cycles, ge, ok);
    total++;
    if (!ok || ge) begin bad++; $display("FAIL retry_done got ok=%0b erro=%0b want ok=1 erro=0", ok, ge); end
    total++;
    if (tr_sig !== 64'h2367_8923_6789_2345) begin
      bad++; $display("FAIL retry_trace got %h want 2367892367892345", tr_sig);
    end
    total++;
    if (esp_len_q.size() != 2 || esp_len_q[0] != TO_LIM || esp_len_q[1] != TO_LIM || esp_rm0 != 0) begin
      bad++; $display("FAIL retry_espera got visits=%0d rm0=%0d want 2 visits of %0d rm0=0",
                      esp_len_q.size(), esp_rm0, TO_LIM);
    end
    total++;
    if (n_start[0] - s0 != 3) begin bad++; $display("FAIL retry_starts got %0d want 3", n_start[0] - s0); end
    cyc(1);
  endtask

  task automatic test_all_timeouts(input int i);
    int cycles, s0, r0, c0, v0; bit ge, ok;
    s0 = n_start[i]; r0 = n_reg[i]; c0 = n_ct[i]; v0 = n_78[i];
    repeat (4) plan_q.push_back(0);
    exp_q.push_back('{i, 1'b1, 4});
    medir[i] = 1'b1;
    run_until_done(i, 500, cycles, ge, ok);
    total++;
    if (!ok || !ge) begin bad++; $display("FAIL timeouts_done inst=%0d got ok=%0b erro=%0b want 1 1", i, ok, ge); end
    total++;
    if (n_start[i] - s0 != 4 || n_ct[i] - c0 != 3 || n_reg[i] - r0 != 0) begin
      bad++; $display("FAIL timeouts_counts inst=%0d got start=%0d ct=%0d reg=%0d want 4 3 0",
                      i, n_start[i] - s0, n_ct[i] - c0, n_reg[i] - r0);
    end
    total++;
    if (i == 0 && tr_sig !== 64'h2367_8923_6789_236A) begin
      bad++; $display("FAIL timeouts_trace inst=0 got %h want 236789236789236A", tr_sig);
    end else if (i == 1 && tr_sig !== 64'h2369_2369_2369_236A) begin
      bad++; $display("FAIL timeouts_trace inst=1 got %h want 236923692369236A", tr_sig);
    end
    if (i == 1) begin
      total++;
      if (n_78[1] - v0 != 0) begin bad++; $display("FAIL direto_no_espera got %0d cycles in 7/8 want 0", n_78[1] - v0); end
    end
    cyc(1);
    total++;
    if (erro[i] !== 1'b0 || db_estado[i] !== 4'h0) begin
      bad++; $display("FAIL erro_pulse inst=%0d got erro=%0b state=%h want 0 0", i, erro[i], db_estado[i]);
    end
  endtask

  task automatic test_simultaneous();
    int cycles; bit ge, ok;
    plan_q.push_back(TO_LIM);
    exp_q.push_back('{0, 1'b0, 1});
    medir[0] = 1'b1;
    run_until_done(0, 100, cycles, ge, ok);
    total++;
    if (!coinc) begin bad++; $display("FAIL simul_setup got coincidence=0 want 1"); end
    total++;
    if (!ok || ge || tr_sig !== 64'h012345) begin
      bad++; $display("FAIL simul_priority got ok=%0b erro=%0b trace=%h want 1 0 012345", ok, ge, tr_sig);
    end
    cyc(1);
  endtask

  task automatic test_async_reset();
    bit ok;
    plan_q.push_back(-3);
    medir[0] = 1'b1;
    cyc(1);
    medir[0] = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      if (db_estado[0] == 4'h8) ok = 1'b1;
      else @(negedge clock);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL reach_espera got state=%h want 8", db_estado[0]); end
    cyc(3);
    #2 reset = 1'b1;
    #1;
    total++;
    if (db_estado[0] !== 4'h0) begin bad++; $display("FAIL async_state got %h want 0", db_estado[0]); end
    total++;
    if ({reset_medida[0], start_medida[0], registra_medida[0], zera_tentativas[0], zera_timeout[0],
         conta_tentativas[0], conta_timeout[0], pronto[0], erro[0]} !== 9'b0) begin
      bad++; $display("FAIL async_outputs got nonzero want 0");
    end
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_ignored_request();
    int cycles, n1; bit ge, ok;
    plan_q.push_back(10);
    exp_q.push_back('{0, 1'b0, 1});
    medir[0] = 1'b1;
    cyc(1);
    medir[0] = 1'b0;
    cyc(2);
    total++;
    if (db_estado[0] !== 4'h3) begin bad++; $display("FAIL ign_aguarda got %h want 3", db_estado[0]); end
    medir[0] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clock);
      if (pronto[0]) ok = 1'b1;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL ign_done got pronto never want pronto"); end
    cyc(1);
    total++;
    if (db_estado[0] !== 4'h0) begin bad++; $display("FAIL ign_back_inicial got %h want 0", db_estado[0]); end
    medir[0] = 1'b0;
    n1 = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (db_estado[0] != 4'h0) n1++;
    end
    total++;
    if (n1 != 0) begin bad++; $display("FAIL ign_no_restart got %0d busy cycles want 0", n1); end
    plan_q.push_back(7);
    exp_q.push_back('{0, 1'b0, 1});
    medir[0] = 1'b1;
    run_until_done(0, 100, cycles, ge, ok);
    total++;
    if (!ok || ge || cycles != 11) begin
      bad++; $display("FAIL back_to_back got ok=%0b erro=%0b cycles=%0d want 1 0 11", ok, ge, cycles);
    end
    cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_success();
    test_retry_success();
    test_all_timeouts(0);
    test_all_timeouts(1);
    test_simultaneous();
    test_async_reset();
    test_ignored_request();
    cyc(2);
    total++;
    if (exp_q.size() != 0 || plan_q.size() != 0) begin
      bad++; $display("FAIL leftover got exp=%0d plan=%0d want 0 0", exp_q.size(), plan_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
